// File: rtl/xor_lookup_reader.sv
// XOR-bank lookup reader: issues one bank read per accepted request, XORs the
// bank slices back into an entry, and forwards write commits that race the read.
module xor_lookup_reader #(
  parameter int NUM_WR      = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int VALUE_WIDTH = 31,
  parameter int KEY_WIDTH   = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int RD_LAT      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en_in,
  input  logic [1:0]                   opt_in,
  input  logic [KEY_WIDTH-1:0]         key_in,
  input  logic [INDEX_WIDTH-1:0]       index_in,
  output logic                         rd_en,
  output logic [INDEX_WIDTH-1:0]       rd_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] rd_data_all,
  input  logic                         wr_valid,
  input  logic [INDEX_WIDTH-1:0]       wr_index,
  input  logic [DATA_WIDTH-1:0]        wr_entry,
  output logic                         out_valid,
  output logic                         out_hit,
  output logic [VALUE_WIDTH-1:0]       out_value,
  output logic [KEY_WIDTH-1:0]         out_key,
  output logic [31:0]                  hit_cnt,
  output logic [31:0]                  miss_cnt
);

  // One slot per cycle from T+1 (read issued) to T+1+RD_LAT (data returned).
  localparam int STAGES    = RD_LAT + 1;
  localparam int VALID_BIT = KEY_WIDTH + VALUE_WIDTH;

  logic                   accept;
  logic [STAGES-1:0]      st_valid;
  logic [STAGES-1:0]      st_fwd;
  logic [STAGES-1:0]      snoop;
  logic [STAGES-1:0]      nxt_fwd;
  logic [KEY_WIDTH-1:0]   st_key    [STAGES];
  logic [INDEX_WIDTH-1:0] st_index  [STAGES];
  logic [DATA_WIDTH-1:0]  st_entry  [STAGES];
  logic [DATA_WIDTH-1:0]  nxt_entry [STAGES];
  logic [DATA_WIDTH-1:0]  xor_data;
  logic [DATA_WIDTH-1:0]  last_entry;

  logic                   e_valid;
  logic [KEY_WIDTH-1:0]   e_key;
  logic [DATA_WIDTH-1:0]  e_entry;
  logic                   e_hit;

  assign accept = en_in && (opt_in == 2'b00);

  // Each slot snoops the commit bus on its own index; a later match overwrites.
  always_comb begin
    snoop   = '0;
    nxt_fwd = '0;
    for (int s = 0; s < STAGES; s++) begin
      snoop[s]     = st_valid[s] && wr_valid && (wr_index == st_index[s]);
      nxt_fwd[s]   = st_fwd[s] || snoop[s];
      nxt_entry[s] = snoop[s] ? wr_entry : st_entry[s];
    end
  end

  always_comb begin
    xor_data = '0;
    for (int b = 0; b < NUM_WR; b++) begin
      xor_data = xor_data ^ rd_data_all[b*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign last_entry = nxt_fwd[STAGES-1] ? nxt_entry[STAGES-1] : xor_data;

  assign e_hit = e_valid && e_entry[VALID_BIT] &&
                 (e_entry[KEY_WIDTH-1:0] == e_key);

  // Control path: valid bits, forward flags, outputs and counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_valid  <= '0;
      st_fwd    <= '0;
      e_valid   <= 1'b0;
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_value <= '0;
      out_key   <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      st_valid  <= {st_valid[STAGES-2:0], accept};
      st_fwd    <= {nxt_fwd[STAGES-2:0], 1'b0};
      e_valid   <= st_valid[STAGES-1];
      out_valid <= e_valid;
      out_hit   <= e_hit;
      out_value <= e_hit ? e_entry[VALID_BIT-1:KEY_WIDTH] : '0;
      out_key   <= e_valid ? e_key : '0;
      if (e_valid && e_hit && (hit_cnt != 32'hFFFF_FFFF)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (e_valid && !e_hit && (miss_cnt != 32'hFFFF_FFFF)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  // Data path carries no reset; it is qualified by the valid bits above.
  always_ff @(posedge clk) begin
    st_key[0]   <= key_in;
    st_index[0] <= index_in;
    st_entry[0] <= '0;
    for (int s = 1; s < STAGES; s++) begin
      st_key[s]   <= st_key[s-1];
      st_index[s] <= st_index[s-1];
      st_entry[s] <= nxt_entry[s-1];
    end
    e_key   <= st_key[STAGES-1];
    e_entry <= last_entry;
  end

  assign rd_en   = st_valid[0];
  assign rd_addr = st_index[0];

endmodule
